cpu_ctrl: RTL and testbench

- Parametrised multi-cycle control unit and datapath core for the CPU family.
- Fetches instructions over a valid/ack memory interface, decodes them and fetches operand words.
- Executes ALU, LOAD, STORE, conditional JUMP and HALT instructions against an internal register file.
- Keeps the zero/carry flags and sits between the program/data memory and the top level.

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/cpu_alu.sv | 34 +++
 rtl/cpu_ctrl.sv | 157 +++++++++++++++
 tb/tb_cpu_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu_ctrl control unit: state encoding,
// instruction field positions, ALU functions and jump conditions.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_OPND   = 4'd3,
    S_EXEC   = 4'd4,
    S_LOAD   = 4'd5,
    S_STORE  = 4'd6,
    S_JUMP   = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  localparam logic [1:0] CLS_ALU   = 2'b00;
  localparam logic [1:0] CLS_LOAD  = 2'b01;
  localparam logic [1:0] CLS_STORE = 2'b10;
  localparam logic [1:0] CLS_JUMP  = 2'b11;

  typedef enum logic [2:0] {
    F_HALT = 3'd0,
    F_ADD  = 3'd1,
    F_SUB  = 3'd2,
    F_AND  = 3'd3,
    F_OR   = 3'd4,
    F_XOR  = 3'd5,
    F_NOT  = 3'd6,
    F_NOP  = 3'd7
  } alu_func_t;

  localparam logic [2:0] J_ALWAYS = 3'd0;
  localparam logic [2:0] J_Z      = 3'd1;
  localparam logic [2:0] J_NZ     = 3'd2;
  localparam logic [2:0] J_C      = 3'd3;
  localparam logic [2:0] J_NC     = 3'd4;

  localparam int CLS_MSB = 7;
  localparam int CLS_LSB = 6;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 3;

  // Conditions 101..111 are never taken, so the jump degrades to a 2-word NOP.
  function automatic logic jump_taken(input logic [2:0] cond, input logic z, input logic c);
    case (cond)
      J_ALWAYS: return 1'b1;
      J_Z:      return z;
      J_NZ:     return ~z;
      J_C:      return c;
      J_NC:     return ~c;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: binary ops on a/b, NOT on b; carry is the ADD carry-out
// or the SUB borrow, zero flags an all-zero result.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_func_t         func,
  output logic [DATA_W-1:0] y,
  output logic              carry,
  output logic              zero
);

  always_comb begin
    y     = a;
    carry = 1'b0;
    case (func)
      F_ADD:   {carry, y} = {1'b0, a} + {1'b0, b};
      F_SUB: begin
        y     = a - b;
        carry = (a < b);
      end
      F_AND:   y = a & b;
      F_OR:    y = a | b;
      F_XOR:   y = a ^ b;
      F_NOT:   y = ~b;
      default: y = a;
    endcase
    zero = (y == '0);
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control unit and datapath: fetch/decode/operand/execute over a
// valid/ack memory port, with a small register file and zero/carry flags.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_o,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic [3:0]        state_o
);

  localparam int RIDX_W = $clog2(NUM_REGS);

  state_t state, state_next;

  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] opr;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              zf, cf;

  logic [1:0]        cls;
  logic [2:0]        fn;
  logic [RIDX_W-1:0] ridx;
  logic [ADDR_W-1:0] target;
  logic [DATA_W-1:0] alu_y;
  logic              alu_carry, alu_zero;
  logic              unused_bits;

  assign cls         = ir[CLS_MSB:CLS_LSB];
  assign fn          = ir[FN_MSB:FN_LSB];
  assign ridx        = ir[RIDX_W-1:0];
  assign target      = opr[ADDR_W-1:0];
  assign unused_bits = ^{ir, opr};

  cpu_alu #(.DATA_W(DATA_W)) alu (
    .a     (regs[0]),
    .b     (regs[ridx]),
    .func  (alu_func_t'(fn)),
    .y     (alu_y),
    .carry (alu_carry),
    .zero  (alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (run) state_next = S_FETCH;
      S_FETCH:  if (mem_ack) state_next = S_DECODE;
      S_DECODE: begin
        if (cls == CLS_ALU) state_next = (fn == F_HALT) ? S_HALT : S_EXEC;
        else                state_next = S_OPND;
      end
      S_OPND: begin
        if (mem_ack) begin
          case (cls)
            CLS_LOAD:  state_next = S_LOAD;
            CLS_STORE: state_next = S_STORE;
            default:   state_next = S_JUMP;
          endcase
        end
      end
      S_EXEC:   state_next = S_FETCH;
      S_LOAD:   if (mem_ack) state_next = S_FETCH;
      S_STORE:  if (mem_ack) state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      S_HALT:   if (run) state_next = S_FETCH;
      default:  state_next = S_IDLE;
    endcase
  end

  // Request fields depend only on state and registers that are frozen while
  // waiting, so they stay stable until the ack arrives.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    halted    = 1'b0;
    case (state)
      S_FETCH, S_OPND: begin
        mem_req  = 1'b1;
        mem_addr = pc;
      end
      S_LOAD: begin
        mem_req  = 1'b1;
        mem_addr = target;
      end
      S_STORE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = target;
        mem_wdata = regs[ridx];
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= '0;
      ir  <= '0;
      opr <= '0;
      zf  <= 1'b0;
      cf  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem_ack) begin
          ir <= mem_rdata;
          pc <= pc + 1'b1;
        end
        S_OPND: if (mem_ack) begin
          opr <= mem_rdata;
          pc  <= pc + 1'b1;
        end
        S_EXEC: if (fn != F_NOP) begin
          regs[0] <= alu_y;
          zf      <= alu_zero;
          if (fn == F_ADD || fn == F_SUB) cf <= alu_carry;
        end
        S_LOAD: if (mem_ack) begin
          regs[ridx] <= mem_rdata;
          zf         <= (mem_rdata == '0);
        end
        S_JUMP: if (jump_taken(fn, zf, cf)) pc <= target;
        default: ;
      endcase
    end
  end

  assign pc_o       = pc;
  assign flag_zero  = zf;
  assign flag_carry = cf;
  assign state_o    = state;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: an instruction-level reference model predicts
// every memory transaction and halt; a monitor compares as the DUT presents them.
module tb_cpu_ctrl;
  import cpu_pkg::*;

  typedef struct {
    bit is_halt;
    bit we;
    int addr;
    int data;
    bit z;
    bit c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        run2 = 1'b0;

  logic        mem_req, mem_we, mem_ack, halted, flag_zero, flag_carry;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata, pc_o;
  logic [3:0]  state_o;

  logic        req2, we2, ack2, halted2, zf2, cf2;
  logic [11:0] addr2, pc2;
  logic [15:0] wdata2, rdata2;
  logic [3:0]  st2;
  logic [11:0] store_addr2 = '0;
  logic [15:0] store_data2 = '1;

  logic [7:0]  mem [256];
  logic [7:0]  image [256];
  logic [15:0] mem2 [64];
  bit          load_img = 1'b1;
  bit          rand_wait = 1'b0;
  int          fixed_wait = 0;
  int          rnd_wait = 0;
  int          wait_cnt = 0;
  int          cur_wait;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic        halt_prev = 1'b0;

  always #5 clk = ~clk;

  cpu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .halted(halted), .pc_o(pc_o),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .state_o(state_o)
  );

  cpu_ctrl #(.DATA_W(16), .ADDR_W(12), .NUM_REGS(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .run(run2),
    .mem_req(req2), .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2),
    .mem_rdata(rdata2), .mem_ack(ack2), .halted(halted2), .pc_o(pc2),
    .flag_zero(zf2), .flag_carry(cf2), .state_o(st2)
  );

  // Memory responder with programmable wait states
  assign cur_wait  = rand_wait ? rnd_wait : fixed_wait;
  assign mem_ack   = mem_req && (wait_cnt >= cur_wait);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (mem_req && mem_ack) begin
      wait_cnt <= 0;
      rnd_wait <= $urandom_range(0, 2);
    end else if (mem_req) wait_cnt <= wait_cnt + 1;
  end

  always @(posedge clk) begin
    if (load_img) for (int i = 0; i < 256; i++) mem[i] <= image[i];
    else if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
  end

  assign rdata2 = mem2[addr2[5:0]];
  assign ack2   = req2;

  always @(posedge clk) begin
    if (req2 && ack2 && we2) begin
      store_addr2 <= addr2;
      store_data2 <= wdata2;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && exp_q.size() > 0) begin
      if (mem_req && mem_ack) begin
        e = exp_q.pop_front();
        checkOutput("event_halted", {31'b0, halted}, {31'b0, e.is_halt});
        checkOutput("mem_addr", {24'b0, mem_addr}, e.addr);
        checkOutput("mem_we", {31'b0, mem_we}, {31'b0, e.we});
        if (e.we) checkOutput("mem_wdata", {24'b0, mem_wdata}, e.data);
      end else if (halted && !halt_prev) begin
        e = exp_q.pop_front();
        checkOutput("halt_event", {31'b0, halted}, {31'b0, e.is_halt});
        checkOutput("halt_pc", {24'b0, pc_o}, e.addr);
        checkOutput("halt_flags", {30'b0, flag_zero, flag_carry}, {30'b0, e.z, e.c});
      end
    end
    halt_prev <= halted;
  end

  task automatic pushMem(input int addr, input bit we, input int data);
    exp_t e;
    e = '{is_halt: 1'b0, we: we, addr: addr, data: data, z: 1'b0, c: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic pushHalt(input int pc, input bit z, input bit c);
    exp_t e;
    e = '{is_halt: 1'b1, we: 1'b0, addr: pc, data: 0, z: z, c: c};
    exp_q.push_back(e);
  endtask

  // Instruction-level reference: executes the image with integer arithmetic
  task automatic buildExpect(input int max_instr);
    int m[256];
    int r[4];
    int pc, ins, cls, fn, ri, op, v;
    bit z, c, taken;
    for (int i = 0; i < 256; i++) m[i] = int'(image[i]);
    for (int i = 0; i < 4; i++) r[i] = 0;
    pc = 0; z = 0; c = 0;
    for (int n = 0; n < max_instr; n++) begin
      ins = m[pc];
      pushMem(pc, 0, 0);
      pc = (pc + 1) % 256;
      cls = ins / 64;
      fn  = (ins / 8) % 8;
      ri  = ins % 4;
      if (cls == 0) begin
        if (fn == 0) begin
          pushHalt(pc, z, c);
          break;
        end
        case (fn)
          1: begin v = r[0] + r[ri]; c = (v > 255); r[0] = v % 256; end
          2: begin c = (r[0] < r[ri]); r[0] = (r[0] - r[ri] + 256) % 256; end
          3: r[0] = r[0] & r[ri];
          4: r[0] = r[0] | r[ri];
          5: r[0] = r[0] ^ r[ri];
          6: r[0] = 255 - r[ri];
          default: ;
        endcase
        if (fn != 7) z = (r[0] == 0);
      end else begin
        op = m[pc];
        pushMem(pc, 0, 0);
        pc = (pc + 1) % 256;
        if (cls == 1) begin
          v = m[op];
          pushMem(op, 0, 0);
          r[ri] = v;
          z = (v == 0);
        end else if (cls == 2) begin
          pushMem(op, 1, r[ri]);
          m[op] = r[ri];
        end else begin
          taken = (fn == 0) || (fn == 1 && z) || (fn == 2 && !z) || (fn == 3 && c) || (fn == 4 && !c);
          if (taken) pc = op;
        end
      end
    end
  endtask

  task automatic clearImage();
    for (int i = 0; i < 256; i++) image[i] = 8'h00;
  endtask

  task automatic resetDut(input bit rnd, input int fw);
    @(negedge clk);
    rst_n = 1'b0;
    load_img = 1'b1;
    rand_wait = rnd;
    fixed_wait = fw;
    exp_q.delete();
    repeat (2) @(negedge clk);
    load_img = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input int max_instr, input bit rnd, input int fw);
    resetDut(rnd, fw);
    buildExpect(max_instr);
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    clearImage();
    for (int i = 0; i < 64; i++) mem2[i] = 16'h0000;

    // Reset values, HALT latency and resume
    repeat (2) @(negedge clk);
    checkOutput("rst_mem_outputs", {14'b0, mem_req, mem_we, mem_addr, mem_wdata}, 0);
    checkOutput("rst_status", {18'b0, halted, flag_zero, flag_carry, pc_o, state_o}, {28'b0, S_IDLE});
    load_img = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    checkOutput("first_fetch", {23'b0, mem_req, mem_addr}, {23'b0, 1'b1, 8'h00});
    @(posedge clk); #1;
    checkOutput("halted_cycle2", {31'b0, halted}, 0);
    @(posedge clk); #1;
    checkOutput("halted_cycle3", {31'b0, halted}, 1);
    checkOutput("halt_pc_flags", {22'b0, pc_o, flag_zero, flag_carry}, {22'b0, 8'h01, 2'b00});
    @(negedge clk);
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    checkOutput("resume_fetch", {23'b0, mem_req, mem_addr}, {23'b0, 1'b1, 8'h01});

    // LOAD/ADD/SUB with flag-driven jumps, zero-wait then random waits
    clearImage();
    image[8'h00] = 8'h40; image[8'h01] = 8'h20; image[8'h02] = 8'h41; image[8'h03] = 8'h21;
    image[8'h04] = 8'h09; image[8'h05] = 8'hC8; image[8'h06] = 8'h40;
    image[8'h20] = 8'hFF; image[8'h21] = 8'h01;
    image[8'h40] = 8'h80; image[8'h41] = 8'h30; image[8'h42] = 8'h11; image[8'h43] = 8'hC8;
    image[8'h44] = 8'h50; image[8'h45] = 8'h81; image[8'h46] = 8'h31; image[8'h47] = 8'h00;
    applyStimulus(50, 1'b0, 0);
    waitDrain("drain_alu_zero_wait", 500);
    applyStimulus(50, 1'b1, 0);
    waitDrain("drain_alu_rand_wait", 1000);

    // STORE held stable across three wait cycles
    clearImage();
    image[8'h00] = 8'h41; image[8'h01] = 8'h21; image[8'h02] = 8'h81; image[8'h03] = 8'h30;
    image[8'h21] = 8'h01;
    applyStimulus(10, 1'b0, 3);
    n = 0;
    while (!(mem_req && mem_we) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("store_seen", {31'b0, mem_req && mem_we}, 1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("store_hold%0d", i), {14'b0, mem_req, mem_we, mem_addr, mem_wdata},
                  {14'b0, 1'b1, 1'b1, 8'h30, 8'h01});
      @(negedge clk);
    end
    checkOutput("after_store", {23'b0, mem_we, mem_addr}, {23'b0, 1'b0, 8'h04});
    waitDrain("drain_store", 500);

    // Asynchronous reset while an operand request is pending
    clearImage();
    image[8'h00] = 8'h40; image[8'h01] = 8'h20;
    resetDut(1'b0, 3);
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    n = 0;
    while (state_o != S_OPND && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("opnd_pending", {27'b0, mem_req, state_o}, {27'b0, 1'b1, S_OPND});
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_mem", {14'b0, mem_req, mem_we, mem_addr, mem_wdata}, 0);
    checkOutput("async_rst_state", {19'b0, halted, pc_o, state_o}, {28'b0, S_IDLE});
    fixed_wait = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    checkOutput("restart_fetch", {23'b0, mem_req, mem_addr}, {23'b0, 1'b1, 8'h00});

    // PC wrap: jump to 0xFF, NOP there, next fetch at 0x00
    clearImage();
    image[8'h00] = 8'hC0; image[8'h01] = 8'hFF; image[8'hFF] = 8'h38;
    applyStimulus(4, 1'b0, 0);
    waitDrain("drain_pc_wrap", 200);

    // Random programs with random wait states
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 256; i++) image[i] = 8'($urandom);
      applyStimulus(40, 1'b1, 0);
      waitDrain($sformatf("drain_random%0d", t), 3000);
    end

    // Wide configuration: 16-bit ADD wraps with carry out
    mem2[0] = 16'hA540; mem2[1] = 16'h7020; mem2[2] = 16'h0041; mem2[3] = 16'h0021;
    mem2[4] = 16'h0009; mem2[5] = 16'h0080; mem2[6] = 16'h0022; mem2[7] = 16'h0000;
    mem2[32] = 16'hFFFF; mem2[33] = 16'h0001;
    @(negedge clk);
    run2 = 1'b1;
    @(negedge clk);
    run2 = 1'b0;
    n = 0;
    while (!halted2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wide_halted", {31'b0, halted2}, 1);
    checkOutput("wide_store", {4'b0, store_addr2, store_data2}, {4'b0, 12'h022, 16'h0000});
    checkOutput("wide_flags", {30'b0, zf2, cf2}, {30'b0, 2'b11});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
